// File: rtl/uart_rx_ctrl_pkg.sv
// uart_rx_ctrl_pkg
// Shared types and constants for the UART RX frame controller:
//   - FSM state encoding
//   - frame bit-index constants
//   - parity type codes
//   - data / counter widths
package uart_rx_ctrl_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int CNT_WIDTH  = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } rx_state_e;

  typedef enum logic {
    PARITY_EVEN = 1'b0,
    PARITY_ODD  = 1'b1
  } parity_type_e;

  localparam logic [CNT_WIDTH-1:0] START_IDX      = 4'd0;
  localparam logic [CNT_WIDTH-1:0] FIRST_DATA_IDX = 4'd1;
  localparam logic [CNT_WIDTH-1:0] LAST_DATA_IDX  = 4'd8;
  localparam logic [CNT_WIDTH-1:0] PAR_IDX        = 4'd9;
  localparam logic [CNT_WIDTH-1:0] STOP_IDX_NOPAR = 4'd9;
  localparam logic [CNT_WIDTH-1:0] STOP_IDX_PAR   = 4'd10;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if
// Bundles the sampler handshake and the checked-byte result.
//   master (controller): drives Enable, edge_count, bit_count, RX_OUT,
//                        data_valid, parity_error, stop_error;
//                        reads P_DATA, parity_bit, stop_bit.
//   slave  (sampler / consumer): the mirror image.
interface uart_rx_ctrl_if;
  import uart_rx_ctrl_pkg::*;

  logic                  Enable;
  logic [CNT_WIDTH-1:0]  edge_count;
  logic [CNT_WIDTH-1:0]  bit_count;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  parity_bit;
  logic                  stop_bit;
  logic [DATA_WIDTH-1:0] RX_OUT;
  logic                  data_valid;
  logic                  parity_error;
  logic                  stop_error;

  modport master (
    output Enable, edge_count, bit_count, RX_OUT, data_valid, parity_error, stop_error,
    input  P_DATA, parity_bit, stop_bit
  );

  modport slave (
    input  Enable, edge_count, bit_count, RX_OUT, data_valid, parity_error, stop_error,
    output P_DATA, parity_bit, stop_bit
  );

endinterface

// File: rtl/rx_edge_bit_counter.sv
// rx_edge_bit_counter
// Oversample edge counter and frame bit counter.
//   CLK, RST (sync, active-low), Enable (count), clear (zero both counters,
//   wins over Enable), prescale (oversampling ratio)
//   edge_count: 0..prescale-1 within the current bit
//   bit_count : index of the current frame bit
module rx_edge_bit_counter
  import uart_rx_ctrl_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      Enable,
  input  logic                      clear,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic [CNT_WIDTH-1:0]      edge_count,
  output logic [CNT_WIDTH-1:0]      bit_count
);

  logic [CNT_WIDTH-1:0] edge_q, edge_d;
  logic [CNT_WIDTH-1:0] bit_q, bit_d;
  logic                 last_edge;

  assign last_edge = (PRESCALE_WIDTH'(edge_q) == prescale - PRESCALE_WIDTH'(1));

  always_comb begin
    edge_d = edge_q;
    bit_d  = bit_q;
    if (clear) begin
      edge_d = '0;
      bit_d  = '0;
    end else if (Enable) begin
      if (last_edge) begin
        edge_d = '0;
        bit_d  = bit_q + 1'b1;
      end else begin
        edge_d = edge_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

  assign edge_count = edge_q;
  assign bit_count  = bit_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
// UART RX frame controller: start detection with glitch rejection, drives
// the sampler counters, checks parity/stop and delivers the byte.
//   CLK, RST (sync, active-low), RX_IN (serial line, idle high)
//   prescale (8 or 16), parity_enable, parity_type (0 even, 1 odd)
//   busy: high in every state except IDLE
//   sif (master): sampler handshake and checked-byte result
//
// state  | meaning
// IDLE   | line idle, counters held at 0
// START  | bit 0; mid-bit re-check of the line rejects glitches
// DATA   | bits 1..8
// PARITY | bit 9 when parity is enabled
// STOP   | last bit; checks evaluated on its final edge
// DONE   | single cycle, result flags visible; may start the next frame
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      parity_enable,
  input  logic                      parity_type,
  output logic                      busy,
  uart_rx_ctrl_if.master            sif
);

  rx_state_e             state_q, state_d;
  logic                  data_valid_q, data_valid_d;
  logic                  parity_error_q, parity_error_d;
  logic                  stop_error_q, stop_error_d;
  logic [DATA_WIDTH-1:0] rx_out_q, rx_out_d;

  logic                  cnt_en, clear;
  logic [CNT_WIDTH-1:0]  edge_count, bit_count;
  logic [CNT_WIDTH-1:0]  last_idx;
  logic                  last_edge, mid_edge;
  logic                  exp_par, perr, serr;

  rx_edge_bit_counter #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_counter (
    .CLK        (CLK),
    .RST        (RST),
    .Enable     (cnt_en),
    .clear      (clear),
    .prescale   (prescale),
    .edge_count (edge_count),
    .bit_count  (bit_count)
  );

  assign last_edge = (PRESCALE_WIDTH'(edge_count) == prescale - PRESCALE_WIDTH'(1));
  assign mid_edge  = (PRESCALE_WIDTH'(edge_count) == (prescale >> 1));
  assign last_idx  = parity_enable ? STOP_IDX_PAR : STOP_IDX_NOPAR;

  assign exp_par = (^sif.P_DATA) ^ (parity_type == PARITY_ODD);
  assign perr    = parity_enable & (sif.parity_bit != exp_par);
  assign serr    = ~sif.stop_bit;

  // The counter is also enabled on the start-detect cycle (IDLE or DONE with
  // the line low) so that cycle counts as edge 0 of bit 0.
  always_comb begin
    state_d        = state_q;
    cnt_en         = 1'b0;
    clear          = 1'b0;
    data_valid_d   = 1'b0;
    parity_error_d = 1'b0;
    stop_error_d   = 1'b0;
    rx_out_d       = rx_out_q;
    case (state_q)
      IDLE: begin
        if (!RX_IN) begin
          state_d = START;
          cnt_en  = 1'b1;
        end
      end
      START: begin
        cnt_en = 1'b1;
        if (mid_edge && RX_IN) begin
          state_d = IDLE;
          clear   = 1'b1;
        end else if (last_edge) begin
          state_d = DATA;
        end
      end
      DATA: begin
        cnt_en = 1'b1;
        if (last_edge && bit_count == LAST_DATA_IDX) begin
          state_d = parity_enable ? PARITY : STOP;
        end
      end
      PARITY: begin
        cnt_en = 1'b1;
        if (last_edge) state_d = STOP;
      end
      STOP: begin
        cnt_en = 1'b1;
        if (last_edge && bit_count == last_idx) begin
          state_d        = DONE;
          clear          = 1'b1;
          parity_error_d = perr;
          stop_error_d   = serr;
          if (!perr && !serr) begin
            data_valid_d = 1'b1;
            rx_out_d     = sif.P_DATA;
          end
        end
      end
      DONE: begin
        if (!RX_IN) begin
          state_d = START;
          cnt_en  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        clear   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q        <= IDLE;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
      rx_out_q       <= '0;
    end else begin
      state_q        <= state_d;
      data_valid_q   <= data_valid_d;
      parity_error_q <= parity_error_d;
      stop_error_q   <= stop_error_d;
      rx_out_q       <= rx_out_d;
    end
  end

  assign busy             = (state_q != IDLE);
  assign sif.Enable       = (state_q == START) || (state_q == DATA) ||
                            (state_q == PARITY) || (state_q == STOP);
  assign sif.edge_count   = edge_count;
  assign sif.bit_count    = bit_count;
  assign sif.RX_OUT       = rx_out_q;
  assign sif.data_valid   = data_valid_q;
  assign sif.parity_error = parity_error_q;
  assign sif.stop_error   = stop_error_q;

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side frame controller for the UART RX path. It detects the start bit and runs the oversampling edge/bit counters that drive the data sampler (`Enable`, `edge_count`, `bit_count`). It consumes the sampler's `P_DATA`, `parity_bit` and `stop_bit`. It then delivers a checked byte with a one-cycle `data_valid`, or a one-cycle error pulse.

## Interface
- `PRESCALE_WIDTH`, 5, width of the `prescale` input.
- `CLK`  in  1  system clock; all logic on rising edge.
- `RST`  in  1  reset, synchronous, active-low.
- `RX_IN`  in  1  serial line; idle high.
- `prescale`  in  PRESCALE_WIDTH  oversampling ratio; legal values 8 and 16.
- `parity_enable`  in  1  1 = frame carries a parity bit.
- `parity_type`  in  1  0 = even, 1 = odd.
- `P_DATA`  in  8  assembled byte from the sampler.
- `parity_bit`  in  1  sampled parity bit from the sampler.
- `stop_bit`  in  1  sampled stop bit from the sampler.
- `Enable`  out  1  sampler enable; high while a frame is being received.
- `edge_count`  out  4  oversample tick within the current bit, 0..prescale-1.
- `bit_count`  out  4  frame bit index: 0 start, 1..8 data, 9 parity or stop, 10 stop.
- `RX_OUT`  out  8  last received byte.
- `data_valid`  out  1  one-cycle pulse; `RX_OUT` is new.
- `parity_error`  out  1  one-cycle pulse.
- `stop_error`  out  1  one-cycle pulse.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE:
  - Counters are held at 0 and `Enable` is 0.
  - `RX_IN`=0 → START. The detection cycle counts as edge 0 of bit 0.
- Counters:
  - While `Enable` is high, `edge_count` increments every cycle.
  - At `edge_count`=prescale-1, `edge_count` wraps to 0 and `bit_count` increments.
  - Last bit index L = 10 when `parity_enable`=1, otherwise 9.
- START:
  - At `edge_count`=prescale/2, if `RX_IN`=1 the start bit is a glitch. The block returns to IDLE, clears the counters and raises no flags.
  - Otherwise START → DATA at the end of bit 0.
- DATA: bits 1..8. At the end of bit 8 → PARITY if `parity_enable`=1, else STOP.
- PARITY: bit 9. At its end → STOP.
- STOP: bit L. At the final edge (`bit_count`=L, `edge_count`=prescale-1), the block evaluates in the same cycle:
  - Expected parity = XOR of `P_DATA` XOR `parity_type`.
  - `perr` = `parity_enable` AND (`parity_bit` ≠ expected).
  - `serr` = NOT `stop_bit`.
  - The results are registered: `parity_error`=perr and `stop_error`=serr.
  - `data_valid`=1 and `RX_OUT`←`P_DATA` only when both perr and serr are 0.
  - The counters are cleared and the FSM moves to DONE.
- DONE:
  - Lasts exactly one cycle; the flags are visible only in this cycle.
  - `Enable`=0.
  - `RX_IN`=0 → START, with the DONE cycle counting as edge 0 (back-to-back frames). Otherwise → IDLE.
- Both error flags may assert in the same cycle.
- `RX_OUT` holds its value until the next error-free frame.
- `prescale`, `parity_enable` and `parity_type` must be held stable while `busy`=1. The block uses their live values.

## Timing
- Reset values: FSM=IDLE; `Enable`, `edge_count`, `bit_count`, `data_valid`, `parity_error`, `stop_error` and `busy` = 0; `RX_OUT`=0x00.
- Reset is synchronous and wins over all other activity. Reset mid-frame → IDLE on the next edge, with no flags.
- The start low is first seen in cycle T0. Then:
  - `edge_count`=1 at T0+1.
  - The final edge of the frame is at T0+N·prescale−1, where N = 10 without parity and 11 with parity.
  - The flags are high in cycle T0+N·prescale.
- `busy`=1 from T0+1 through the DONE cycle.
- Every bit passes through `edge_count`=1, which the sampler uses to clear its vote counter.

## Structure
- Shared package holds:
  - State encoding.
  - Bit-index constants: START_IDX=0, FIRST_DATA_IDX=1, LAST_DATA_IDX=8, PAR_IDX=9, STOP_IDX_NOPAR=9, STOP_IDX_PAR=10.
  - Parity type codes.
- Sub-module `rx_edge_bit_counter` holds the edge/bit counters. Its inputs are `CLK`, `RST`, `Enable`, `clear` and `prescale`; its outputs are `edge_count` and `bit_count`.
- FSM and checks live in the top level.

## Test plan
- No parity, prescale=8, byte 0xA5 with valid stop → `data_valid` for one cycle at T0+80, `RX_OUT`=0xA5, no errors.
- Even parity, prescale=16, 0x3C with parity bit 0 → valid at T0+176, `RX_OUT`=0x3C. Repeat with parity bit 1 → `parity_error` pulse only, `RX_OUT` unchanged.
- Stop bit driven 0 with parity also wrong → `parity_error` and `stop_error` in the same cycle, `data_valid`=0.
- `RX_IN` low for 2 cycles only at prescale=8 → back to IDLE by edge 5, no flags, `busy` drops.
- Odd parity, prescale=8, 0x00 then 0xFF back-to-back, the second start beginning on the DONE cycle → two `data_valid` pulses, 88 cycles apart.
- `RST`=0 asserted during bit 4 → next cycle all outputs at reset values. A subsequent frame with 0x5A is received correctly.
